// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter and instruction fetch for the RISC-V core.
// Fetches 32-bit words over a req/ack handshake, holds each one for the decode
// stage, then takes the resolved redirect (PCSrc/pc_target) to form the next PC.
// A misaligned next PC parks the unit in HALT with a sticky fetch_error.
// Only XLEN = 32 is supported; RESET_PC must be 4-byte aligned.
module instr_fetch_unit #(
   parameter int unsigned         XLEN     = 32,
   parameter logic [XLEN-1:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   // instruction memory
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   // decode interface
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [6:0]        op,
   output logic [2:0]        funct3,
   output logic              funct7,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   pc_plus4,
   input  logic              PCSrc,
   input  logic [XLEN-1:0]   pc_target,
   output logic              fetch_error
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_t            r_state;
   logic [XLEN-1:0]   r_pc;
   logic [31:0]       r_instr;
   logic              r_fetch_error;

   logic [XLEN-1:0]   w_pc_plus4;
   logic [XLEN-1:0]   w_next_pc;
   logic              w_misaligned;

   // next-PC selection: redirect target or sequential, wrapping at 2^XLEN
   always_comb begin
      w_pc_plus4   = r_pc + XLEN'(4);
      w_next_pc    = PCSrc ? pc_target : w_pc_plus4;
      w_misaligned = (w_next_pc[1:0] != 2'b00);
   end

   // fetch / hold / halt sequencing with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= NOP_INSTR;
         r_fetch_error <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ack) begin
                  r_instr <= imem_rdata;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (instr_ready) begin
                  if (w_misaligned) begin
                     r_fetch_error <= 1'b1;
                     r_state       <= S_HALT;
                  end else begin
                     r_pc    <= w_next_pc;
                     r_state <= S_FETCH;
                  end
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   // output views; req/valid are masked while reset_n is low so nothing
   // is requested or presented during a reset cycle
   always_comb begin
      imem_req    = (r_state == S_FETCH) && reset_n;
      instr_valid = (r_state == S_HOLD)  && reset_n;
      imem_addr   = r_pc;
      instr       = r_instr;
      op          = r_instr[6:0];
      funct3      = r_instr[14:12];
      funct7      = r_instr[30];
      pc          = r_pc;
      pc_plus4    = w_pc_plus4;
      fetch_error = r_fetch_error;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model answers fetches, a
// reference model tracks the architectural PC, and a monitor checks every
// fetch address and every presented instruction against queued expectations.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        PCSrc = 1'b0;
   logic [31:0] pc_target = '0;
   logic        fetch_error;

   // owned by the monitor
   int tests = 0;
   int fails = 0;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } exp_t;
   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] m_pc = RST_PC;
   logic [31:0] nxt;
   bit          m_halted = 0;
   bit          m_after_reset = 0;
   bit          hold_chk = 0;
   bit          acc;
   int          stall = 0;
   int          tmo_seen = 0;
   int          tp_cnt = 0;
   bit          tp_prev = 0;
   int          ac_cnt = 0;
   bit          ac_prev = 0;

   // owned by the stimulus
   int          tmo_cnt = 0;
   bit          tp_win = 0;
   bit          ac_win = 0;
   int          halt_cnt = 0;

   instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .op(op), .funct3(funct3), .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4),
      .PCSrc(PCSrc), .pc_target(pc_target), .fetch_error(fetch_error)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h4000_0033;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // memory returns garbage unless it is acknowledging
   assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard, sampling on the falling edge
   always @(negedge clk) begin
      acc = 0;
      if (tmo_cnt != tmo_seen) begin
         chk("wait_timeout", tmo_cnt, tmo_seen);
         tmo_seen = tmo_cnt;
      end
      if (!reset_n) begin
         chk("req_low_in_reset", imem_req, 0);
         chk("valid_low_in_reset", instr_valid, 0);
         m_pc = RST_PC;
         exp_q.delete();
         m_halted = 0;
         m_after_reset = 1;
         hold_chk = 0;
         stall = 0;
      end else begin
         if (m_after_reset) begin
            chk("rst_req", imem_req, 1);
            chk("rst_valid", instr_valid, 0);
            chk("rst_err", fetch_error, 0);
            chk("rst_pc", pc, RST_PC);
            chk("rst_instr", instr, NOP);
            m_after_reset = 0;
         end
         if (m_halted) begin
            chk("halt_err", fetch_error, 1);
            chk("halt_req", imem_req, 0);
            chk("halt_valid", instr_valid, 0);
            chk("halt_pc", pc, m_pc);
         end else begin
            chk("err_clear", fetch_error, 0);
            if (hold_chk) begin
               chk("bp_valid_held", instr_valid, 1);
               hold_chk = 0;
            end
            if (imem_req) begin
               chk("fetch_addr", imem_addr, m_pc);
               chk("valid_during_fetch", instr_valid, 0);
               if (imem_ack) exp_q.push_back('{m_pc, mem_word(m_pc)});
            end
            if (instr_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_valid", exp_q.size(), 1);
               end else begin
                  e = exp_q[0];
                  chk("instr", instr, e.word);
                  chk("pc", pc, e.addr);
                  chk("pc_plus4", pc_plus4, e.addr + 32'd4);
                  chk("op", {25'd0, op}, {25'd0, e.word[6:0]});
                  chk("funct3", {29'd0, funct3}, {29'd0, e.word[14:12]});
                  chk("funct7", {31'd0, funct7}, {31'd0, e.word[30]});
                  if (instr_ready) begin
                     void'(exp_q.pop_front());
                     acc = 1;
                     stall = 0;
                     nxt = PCSrc ? pc_target : (e.addr + 32'd4);
                     if (nxt[1:0] != 2'b00) m_halted = 1;
                     else m_pc = nxt;
                  end else begin
                     hold_chk = 1;
                  end
               end
            end
            stall++;
            if (stall > 300) begin
               chk("progress", stall, 0);
               stall = 0;
            end
         end
      end
      if (tp_win) tp_cnt += int'(instr_valid);
      if (tp_prev && !tp_win) begin
         chk("throughput_valid_pulses", tp_cnt, 4);
         tp_cnt = 0;
      end
      tp_prev = tp_win;
      if (ac_win) ac_cnt += int'(acc);
      if (ac_prev && !ac_win) begin
         chk("one_accept", ac_cnt, 1);
         ac_cnt = 0;
      end
      ac_prev = ac_win;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (instr_valid) return;
         step();
      end
      tmo_cnt++;
   endtask

   task automatic wait_valid_pc(input logic [31:0] a, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (instr_valid && pc == a) return;
         step();
      end
      tmo_cnt++;
   endtask

   task automatic wait_req(input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (imem_req) return;
         step();
      end
      tmo_cnt++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      // reset with ack held high: the acks must be ignored
      reset_n = 0; imem_ack = 1; instr_ready = 1; PCSrc = 0; pc_target = '0;
      step(); step();
      reset_n = 1;

      // zero-wait memory, always ready: one instruction every two cycles
      tp_win = 1;
      repeat (8) step();
      tp_win = 0;

      // taken redirect from 0x10 to 0x40
      wait_valid_pc(32'h10, 40);
      PCSrc = 1; pc_target = 32'h40;
      step();
      PCSrc = 0;

      // three wait states, then five cycles of back-pressure, then one accept
      imem_ack = 0; instr_ready = 0;
      wait_req(20);
      repeat (3) step();
      imem_ack = 1;
      step();
      imem_ack = 0;
      ac_win = 1;
      repeat (5) step();
      instr_ready = 1;
      step();
      instr_ready = 0;
      repeat (2) step();
      ac_win = 0;
      imem_ack = 1;

      // misaligned redirect halts until reset
      wait_valid(20);
      PCSrc = 1; pc_target = 32'h42; instr_ready = 1;
      step();
      PCSrc = 0;
      repeat (12) step();
      reset_n = 0;
      step();
      reset_n = 1;
      repeat (4) step();

      // reset while waiting on ack, with ack in the reset cycle
      imem_ack = 0; instr_ready = 1;
      wait_req(20);
      step(); step();
      reset_n = 0; imem_ack = 1;
      step();
      reset_n = 1; imem_ack = 0;
      step();
      imem_ack = 1;

      // PC wrap: 0xFFFF_FFFC + 4 fetches 0x0
      instr_ready = 0;
      wait_valid(20);
      PCSrc = 1; pc_target = 32'hFFFF_FFFC; instr_ready = 1;
      step();
      PCSrc = 0;
      wait_valid_pc(32'hFFFF_FFFC, 20);
      repeat (4) step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         imem_ack    = ($urandom_range(0, 3) != 0);
         instr_ready = ($urandom_range(0, 2) != 0);
         PCSrc       = ($urandom_range(0, 3) == 0);
         pc_target   = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 39) == 0) pc_target[1:0] = 2'($urandom_range(1, 3));
         if (fetch_error) halt_cnt++;
         if (halt_cnt > 12) begin
            reset_n = 0;
            halt_cnt = 0;
         end else begin
            reset_n = ($urandom_range(0, 199) != 0);
         end
         step();
      end
      reset_n = 1;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
